ex_mem_latch: RTL and testbench

//  EX/MEM pipeline register of the 5-stage core. Sits directly downstream of the ID/EX latch and the execute stage.

---
 rtl/ex_mem_latch.sv | 117 +++++++++++
 tb/tb_ex_mem_latch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_latch.sv
// rtl/ex_mem_latch.sv - EX/MEM pipeline register with data-cache request FSM
// Holds a load/store request until dhit and stalls upstream stages meanwhile.
module ex_mem_latch #(
  parameter int WORD_W = 32,
  parameter int RSEL_W = 5,
  parameter int WMUX_W = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_en,
  input  logic              flush,
  input  logic [WORD_W-1:0] npc_i,
  input  logic [WORD_W-1:0] alu_out_i,
  input  logic [WORD_W-1:0] rdat2_i,
  input  logic [WORD_W-1:0] LUI_i,
  input  logic [WORD_W-1:0] imemload_i,
  input  logic [RSEL_W-1:0] wsel_i,
  input  logic              wen_i,
  input  logic              d_ren_i,
  input  logic              d_wen_i,
  input  logic [WMUX_W-1:0] W_mux_i,
  input  logic              halt_i,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic [WORD_W-1:0] npc_o,
  output logic [WORD_W-1:0] alu_out_o,
  output logic [WORD_W-1:0] LUI_o,
  output logic [WORD_W-1:0] imemload_o,
  output logic [RSEL_W-1:0] wsel_o,
  output logic              wen_o,
  output logic [WMUX_W-1:0] W_mux_o,
  output logic              halt_o,
  output logic [WORD_W-1:0] dload_o,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_busy,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state;
  logic   d_ren_o;
  logic   d_wen_o;
  logic   accept;
  logic   req_hit;

  assign mem_busy  = (state == REQ) & ~dhit;
  assign req_hit   = (state == REQ) & dhit;
  assign accept    = ex_en & ~mem_busy & ~halt_o;
  assign dmemREN   = (state == REQ) & d_ren_o;
  assign dmemWEN   = (state == REQ) & d_wen_o;
  assign dmemaddr  = alu_out_o;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      npc_o      <= '0;
      alu_out_o  <= '0;
      LUI_o      <= '0;
      imemload_o <= '0;
      wsel_o     <= '0;
      wen_o      <= 1'b0;
      W_mux_o    <= '0;
      halt_o     <= 1'b0;
      dload_o    <= '0;
      dmemstore  <= '0;
      d_ren_o    <= 1'b0;
      d_wen_o    <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      if (mem_busy && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;

      if (req_hit) begin
        if (d_ren_o)
          dload_o <= dmemload;
        state <= DONE;
      end

      // An accept on the dhit cycle overrides the completion above.
      if (accept) begin
        if (flush) begin
          state      <= IDLE;
          npc_o      <= '0;
          alu_out_o  <= '0;
          LUI_o      <= '0;
          imemload_o <= '0;
          wsel_o     <= '0;
          wen_o      <= 1'b0;
          W_mux_o    <= '0;
          halt_o     <= 1'b0;
          dload_o    <= '0;
          dmemstore  <= '0;
          d_ren_o    <= 1'b0;
          d_wen_o    <= 1'b0;
        end else begin
          state      <= (d_ren_i | d_wen_i) ? REQ : IDLE;
          npc_o      <= npc_i;
          alu_out_o  <= alu_out_i;
          LUI_o      <= LUI_i;
          imemload_o <= imemload_i;
          wsel_o     <= wsel_i;
          wen_o      <= wen_i;
          W_mux_o    <= W_mux_i;
          halt_o     <= halt_i;
          dmemstore  <= rdat2_i;
          d_ren_o    <= d_ren_i & ~d_wen_i;
          d_wen_o    <= d_wen_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_latch.sv
// tb/tb_ex_mem_latch.sv - self-checking bench for ex_mem_latch
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_ex_mem_latch;

  logic        CLK, nRST, ex_en, flush;
  logic [31:0] npc_i, alu_out_i, rdat2_i, LUI_i, imemload_i, dmemload;
  logic [4:0]  wsel_i;
  logic        wen_i, d_ren_i, d_wen_i, halt_i, dhit;
  logic [1:0]  W_mux_i;
  logic [31:0] npc_o, alu_out_o, LUI_o, imemload_o, dload_o, dmemaddr, dmemstore, stall_cnt;
  logic [4:0]  wsel_o;
  logic        wen_o, halt_o, dmemREN, dmemWEN, mem_busy;
  logic [1:0]  W_mux_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_latch dut (
    .CLK(CLK), .nRST(nRST), .ex_en(ex_en), .flush(flush),
    .npc_i(npc_i), .alu_out_i(alu_out_i), .rdat2_i(rdat2_i), .LUI_i(LUI_i),
    .imemload_i(imemload_i), .wsel_i(wsel_i), .wen_i(wen_i), .d_ren_i(d_ren_i),
    .d_wen_i(d_wen_i), .W_mux_i(W_mux_i), .halt_i(halt_i), .dhit(dhit),
    .dmemload(dmemload), .npc_o(npc_o), .alu_out_o(alu_out_o), .LUI_o(LUI_o),
    .imemload_o(imemload_o), .wsel_o(wsel_o), .wen_o(wen_o), .W_mux_o(W_mux_o),
    .halt_o(halt_o), .dload_o(dload_o), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_busy(mem_busy),
    .stall_cnt(stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: the latched instruction plus whether its cache access is still owed.
  typedef struct packed {
    logic [31:0] npc, alu, lui, imem, store, dload, cnt;
    logic [4:0]  wsel;
    logic        wen;
    logic [1:0]  wmux;
    logic        halt, is_load, is_store, pending;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_next(mdl_t c);
    mdl_t n;
    logic busy, acc;
    logic [31:0] cnt;
    n    = c;
    busy = c.pending & ~dhit;
    acc  = ex_en & ~busy & ~c.halt;
    cnt  = (busy && c.cnt != 32'hFFFF_FFFF) ? c.cnt + 32'd1 : c.cnt;
    if (c.pending && dhit) begin
      if (c.is_load) n.dload = dmemload;
      n.pending = 1'b0;
    end
    if (acc && flush) begin
      n = '0;
    end else if (acc) begin
      n.npc = npc_i; n.alu = alu_out_i; n.lui = LUI_i; n.imem = imemload_i;
      n.store = rdat2_i; n.wsel = wsel_i; n.wen = wen_i; n.wmux = W_mux_i;
      n.halt = halt_i; n.is_store = d_wen_i; n.is_load = d_ren_i & ~d_wen_i;
      n.pending = d_ren_i | d_wen_i;
    end
    n.cnt = cnt;
    return n;
  endfunction

  function automatic logic [267:0] model_vec();
    return {m.npc, m.alu, m.lui, m.imem, m.wsel, m.wen, m.wmux, m.halt, m.dload,
            m.pending & m.is_load, m.pending & m.is_store, m.alu, m.store,
            m.pending & ~dhit, m.cnt};
  endfunction

  function automatic logic [267:0] dut_vec();
    return {npc_o, alu_out_o, LUI_o, imemload_o, wsel_o, wen_o, W_mux_o, halt_o, dload_o,
            dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy, stall_cnt};
  endfunction

  task automatic tick();
    mdl_t n;
    n = model_next(m);
    @(posedge CLK);
    m = n;
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    ex_en = 0; flush = 0; npc_i = 0; alu_out_i = 0; rdat2_i = 0; LUI_i = 0;
    imemload_i = 0; wsel_i = 0; wen_i = 0; d_ren_i = 0; d_wen_i = 0; W_mux_i = 0;
    halt_i = 0; dhit = 0; dmemload = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 0;
    #2;
    nRST = 1;
    m = '0;
  endtask

  task automatic test_reset();
    nRST = 0;
    idle_inputs();
    m = '0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (dut_vec() !== 268'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=0", dut_vec());
    end
    nRST = 1;
  endtask

  task automatic test_alu();
    idle_inputs();
    ex_en = 1; alu_out_i = 32'h10; wsel_i = 3; wen_i = 1; npc_i = 32'h104;
    tick();
    ex_en = 0;
    n_checks++;
    if (alu_out_o !== 32'h10 || wsel_o !== 5'd3 || wen_o !== 1'b1 ||
        dmemREN !== 1'b0 || dmemWEN !== 1'b0 || mem_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_op got alu=%h wsel=%0d wen=%b ren=%b wr=%b busy=%b want alu=10 wsel=3 wen=1 ren=0 wr=0 busy=0",
               alu_out_o, wsel_o, wen_o, dmemREN, dmemWEN, mem_busy);
    end
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL alu_model got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_load();
    int ren_cycles = 0, busy_cycles = 0;
    idle_inputs();
    ex_en = 1; d_ren_i = 1; alu_out_i = 32'h40; wsel_i = 8; wen_i = 1;
    tick();
    idle_inputs();
    dmemload = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      dhit = (k == 2);
      #1;
      ren_cycles  += int'(dmemREN);
      busy_cycles += int'(mem_busy);
      n_checks++;
      if (dmemaddr !== 32'h40) begin
        n_fail++;
        $display("FAIL load_addr got=%h want=40", dmemaddr);
      end
      tick();
    end
    dhit = 0;
    #1;
    n_checks++;
    if (ren_cycles != 3 || busy_cycles != 2 || dmemREN !== 1'b0 ||
        dload_o !== 32'hDEAD_BEEF || stall_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL load_seq got ren_cyc=%0d busy_cyc=%0d ren_now=%b dload=%h stall=%0d want 3 2 0 deadbeef 2",
               ren_cycles, busy_cycles, dmemREN, dload_o, stall_cnt);
    end
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL load_model got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_store();
    idle_inputs();
    ex_en = 1; d_wen_i = 1; alu_out_i = 32'h80; rdat2_i = 32'h1234;
    tick();
    idle_inputs();
    dhit = 1;
    #1;
    n_checks++;
    if (dmemWEN !== 1'b1 || mem_busy !== 1'b0 || dmemstore !== 32'h1234 || dmemaddr !== 32'h80) begin
      n_fail++;
      $display("FAIL store_req got wr=%b busy=%b store=%h addr=%h want 1 0 1234 80",
               dmemWEN, mem_busy, dmemstore, dmemaddr);
    end
    tick();
    dhit = 0;
    #1;
    n_checks++;
    if (dmemWEN !== 1'b0 || mem_busy !== 1'b0 || stall_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL store_done got wr=%b busy=%b stall=%0d want 0 0 2", dmemWEN, mem_busy, stall_cnt);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    ex_en = 1; d_ren_i = 1; alu_out_i = 32'h44; wsel_i = 9; wen_i = 1;
    tick();
    idle_inputs();
    ex_en = 1; flush = 1; alu_out_i = 32'h99; dhit = 0;
    tick();
    tick();
    n_checks++;
    if (alu_out_o !== 32'h44 || wsel_o !== 5'd9 || dmemREN !== 1'b1 || mem_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ignored got alu=%h wsel=%0d ren=%b busy=%b want 44 9 1 1",
               alu_out_o, wsel_o, dmemREN, mem_busy);
    end
    dhit = 1; dmemload = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    n_checks++;
    if (dut_vec() !== model_vec() || alu_out_o !== 32'h0 || wsel_o !== 5'd0 ||
        dload_o !== 32'h0 || dmemREN !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_on_hit got alu=%h wsel=%0d dload=%h ren=%b want all 0",
               alu_out_o, wsel_o, dload_o, dmemREN);
    end
  endtask

  task automatic test_halt();
    idle_inputs();
    ex_en = 1; halt_i = 1; alu_out_i = 32'h55;
    tick();
    halt_i = 0;
    n_checks++;
    if (halt_o !== 1'b1 || alu_out_o !== 32'h55) begin
      n_fail++;
      $display("FAIL halt_set got halt=%b alu=%h want 1 55", halt_o, alu_out_o);
    end
    alu_out_i = 32'hAA; wsel_i = 7; flush = 0;
    tick();
    flush = 1;
    tick();
    n_checks++;
    if (halt_o !== 1'b1 || alu_out_o !== 32'h55 || wsel_o !== 5'd0 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL halt_sticky got halt=%b alu=%h wsel=%0d want 1 55 0", halt_o, alu_out_o, wsel_o);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    idle_inputs();
    @(negedge CLK);
    ex_en = 1; d_wen_i = 1; halt_i = 1; alu_out_i = 32'h100; rdat2_i = 32'h77;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (dmemWEN !== 1'b1 || mem_busy !== 1'b1 || halt_o !== 1'b1 || stall_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL areset_pre got wr=%b busy=%b halt=%b stall=%0d want 1 1 1 1",
               dmemWEN, mem_busy, halt_o, stall_cnt);
    end
    #2;
    nRST = 0;
    #1;
    n_checks++;
    if (dmemWEN !== 1'b0 || mem_busy !== 1'b0 || halt_o !== 1'b0 || stall_cnt !== 32'd0 ||
        dut_vec() !== 268'd0) begin
      n_fail++;
      $display("FAIL areset_drop got wr=%b busy=%b halt=%b stall=%0d want 0 0 0 0",
               dmemWEN, mem_busy, halt_o, stall_cnt);
    end
    m = '0;
    @(negedge CLK);
    nRST = 1;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      if (m.halt && $urandom_range(0, 7) == 0) do_reset();
      ex_en      = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 9) < 2);
      d_ren_i    = ($urandom_range(0, 9) < 3);
      d_wen_i    = ($urandom_range(0, 9) < 3);
      halt_i     = ($urandom_range(0, 49) == 0);
      dhit       = ($urandom_range(0, 9) < 4);
      npc_i      = $urandom;
      alu_out_i  = $urandom;
      rdat2_i    = $urandom;
      LUI_i      = $urandom;
      imemload_i = $urandom;
      dmemload   = $urandom;
      wsel_i     = 5'($urandom);
      wen_i      = 1'($urandom);
      W_mux_i    = 2'($urandom);
      #1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        errs++;
        if (errs < 5) $display("FAIL random_pre cyc=%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        errs++;
        if (errs < 5) $display("FAIL random_post cyc=%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    @(negedge CLK);
    test_alu();
    test_load();
    test_store();
    test_flush();
    test_halt();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
